vid_stream_meter: RTL
=====================

Name: vid_stream_meter

Overview:
- Receiving end of the pixel stream protocol (di/de/hs/vs), i.e. the same interface the horizontal scaler consumes and produces.
- Measures frame geometry: active pixels per line and lines per frame.
- Checks that every line in a frame has the same length.
- Optionally checks pixel data against the standard coordinate test pattern.
- Sits on any stream tap (scaler input or output) so sims and hardware bring-up can self-check without writing a BMP.

Parameters:
- PIXEL_WIDTH, 8, pixel data width; must be even.
- CNT_WIDTH, 16, width of the x/y counters and of the reported sizes.
- PATTERN_CHECK, 1, 1 enables the pattern comparison; 0 ties pattern_err_o, err_cnt_o, err_x_o and err_y_o to 0.
- ERR_CNT_WIDTH, 16, width of the saturating error counter.

Ports:
- clk  in  1  single clock for the whole block.
- rst_n  in  1  synchronous reset, active-low.
- di_i  in  PIXEL_WIDTH  pixel data, valid when de_i=1.
- de_i  in  1  pixel valid; gaps between pixels are allowed.
- hs_i  in  1  one-cycle line-start pulse, issued before the line's first pixel.
- vs_i  in  1  one-cycle frame-start pulse, coincident with the hs_i of the first line.
- clr_i  in  1  clears the sticky flags and the error counter/location; frame measurement is not affected.
- frame_w_o  out  CNT_WIDTH  pixel count of the first line of the last completed frame.
- frame_h_o  out  CNT_WIDTH  line count of the last completed frame.
- frame_done_o  out  1  one-cycle pulse when frame_w_o/frame_h_o update.
- line_len_err_o  out  1  sticky: a line length differed from the frame's first line.
- sync_err_o  out  1  sticky: vs_i seen without hs_i.
- ovf_o  out  1  sticky: the x or y counter saturated.
- pattern_err_o  out  1  sticky: pixel mismatch.
- err_cnt_o  out  ERR_CNT_WIDTH  saturating count of mismatched pixels.
- err_x_o, err_y_o  out  CNT_WIDTH each  coordinates of the first mismatch since the last reset/clr_i.

Behaviour:
- Reset (rst_n=0 at a clk edge): all outputs and counters go to 0 and the FSM goes to IDLE. This also applies mid-frame; the partial frame is discarded.
- FSM states:
  - IDLE: ignores de_i and hs_i alone; vs_i&hs_i moves to ACTIVE with x=0, y=0, first=1.
  - ACTIVE, on hs_i without vs_i (line end + new line):
    - if first=1: ref_w<=x, first<=0;
    - else if x!=ref_w: line_len_err_o<=1;
    - then y<=y+1, x<=0.
  - ACTIVE, on vs_i&hs_i (frame boundary):
    - close the current line exactly as above;
    - then frame_w_o<=ref_w (or x if the frame had only one line), frame_h_o<=y+1, frame_done_o=1 on the next cycle;
    - restart with x=0, y=0, first=1.
  - ACTIVE, on de_i: x<=x+1, saturating at all-ones; saturation sets ovf_o. The y counter also saturates and sets ovf_o.
- Frame completion is only detected at the next frame start. frame_done_o latency is 1 clk after the vs_i&hs_i cycle.
- A zero-pixel line counts as a line of width 0.
- Simultaneous de_i with hs_i: hs_i is processed first and the pixel becomes x=0 of the new line.
- vs_i without hs_i: sync_err_o<=1; the pulse is otherwise ignored.
- Pattern check (PATTERN_CHECK=1, ACTIVE, de_i=1), with H=PIXEL_WIDTH/2:
  - expected lower H bits = (x+1) mod 2^H;
  - expected upper H bits = y mod 2^H;
  - here x is the count before the increment.
- On a pattern mismatch:
  - pattern_err_o<=1;
  - err_cnt_o increments, saturating;
  - err_x_o/err_y_o are captured only if err_cnt_o was 0.
- Pattern errors are registered; they are visible 1 clk after the offending de_i.
- clr_i has priority over an error flagged in the same cycle: the result is cleared.
- frame_w_o and frame_h_o hold their values until the next completed frame.

Test Plan:
- 3 frame starts of 2688x34, pattern-correct, DE_I_PERIOD=0 -> frame_done_o pulses twice; frame_w_o=2688, frame_h_o=34; all error flags 0.
- Same stream with DE_I_PERIOD=4 (3 idle cycles per pixel) -> identical results to the DE_I_PERIOD=0 case.
- Line 5 shortened to 2687 pixels -> line_len_err_o=1 after the hs_i of line 6; frame_w_o=2688, frame_h_o=34.
- Pixel (x=10, y=3) corrupted to 0x00 -> pattern_err_o=1, err_cnt_o=1, err_x_o=10, err_y_o=3; pulse clr_i -> all three fields cleared to 0.
- rst_n low for 1 clk at line 17 of frame 1, then frames continue -> no frame_done_o until the second frame start after reset; the following frame reports 2688x34.
- CNT_WIDTH=4 with a 20-pixel line -> x saturates at 15 and ovf_o=1; vs_i pulsed alone -> sync_err_o=1.

Source files
------------

// File: rtl/vid_stream_meter.sv
// Pixel stream meter: measures frame width/height, flags sync, overflow, line-length and test-pattern errors.
// Frame results appear 1 clk after the next vs_i&hs_i; pattern errors 1 clk after the pixel; never stalls the stream.
module vid_stream_meter #(
  parameter int PIXEL_WIDTH   = 8,
  parameter int CNT_WIDTH     = 16,
  parameter int PATTERN_CHECK = 1,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [PIXEL_WIDTH-1:0]   di_i,
  input  logic                     de_i,
  input  logic                     hs_i,
  input  logic                     vs_i,
  input  logic                     clr_i,
  output logic [CNT_WIDTH-1:0]     frame_w_o,
  output logic [CNT_WIDTH-1:0]     frame_h_o,
  output logic                     frame_done_o,
  output logic                     line_len_err_o,
  output logic                     sync_err_o,
  output logic                     ovf_o,
  output logic                     pattern_err_o,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt_o,
  output logic [CNT_WIDTH-1:0]     err_x_o,
  output logic [CNT_WIDTH-1:0]     err_y_o
);

  localparam int H = PIXEL_WIDTH / 2;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] x, y, ref_w;
  logic                 first;
  logic                 sof, y_sat;
  logic [CNT_WIDTH-1:0] y_inc;

  always_comb begin
    sof   = vs_i & hs_i;
    y_sat = (y == CNT_MAX);
    y_inc = y_sat ? y : y + CNT_WIDTH'(1);
  end

  // A pixel arriving with hs_i is x=0 of the new line, so x restarts at 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      x              <= '0;
      y              <= '0;
      ref_w          <= '0;
      first          <= 1'b0;
      frame_w_o      <= '0;
      frame_h_o      <= '0;
      frame_done_o   <= 1'b0;
      line_len_err_o <= 1'b0;
      sync_err_o     <= 1'b0;
      ovf_o          <= 1'b0;
    end else begin
      frame_done_o <= 1'b0;
      if (sof) begin
        if (state == ACTIVE) begin
          if (!first && (x != ref_w)) line_len_err_o <= 1'b1;
          if (y_sat) ovf_o <= 1'b1;
          frame_w_o    <= first ? x : ref_w;
          frame_h_o    <= y_inc;
          frame_done_o <= 1'b1;
        end
        state <= ACTIVE;
        first <= 1'b1;
        y     <= '0;
        x     <= de_i ? CNT_WIDTH'(1) : '0;
      end else if (state == ACTIVE) begin
        if (hs_i) begin
          if (first) begin
            ref_w <= x;
            first <= 1'b0;
          end else if (x != ref_w) begin
            line_len_err_o <= 1'b1;
          end
          if (y_sat) ovf_o <= 1'b1;
          y <= y_inc;
          x <= de_i ? CNT_WIDTH'(1) : '0;
        end else if (de_i) begin
          if (x == CNT_MAX) ovf_o <= 1'b1;
          else              x <= x + CNT_WIDTH'(1);
        end
      end
      if (vs_i && !hs_i) sync_err_o <= 1'b1;
      if (clr_i) begin
        line_len_err_o <= 1'b0;
        sync_err_o     <= 1'b0;
        ovf_o          <= 1'b0;
      end
    end
  end

  if (PATTERN_CHECK != 0) begin : g_pat
    localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX = '1;
    logic [CNT_WIDTH-1:0]   pix_x, pix_y;
    logic [PIXEL_WIDTH-1:0] exp_pix;
    logic                   pix_vld, mismatch;

    always_comb begin
      pix_x    = hs_i ? '0 : x;
      pix_y    = sof ? '0 : (hs_i ? y_inc : y);
      pix_vld  = de_i & ((state == ACTIVE) | sof);
      exp_pix  = {H'(pix_y), H'(pix_x + CNT_WIDTH'(1))};
      mismatch = pix_vld & (di_i != exp_pix);
    end

    always_ff @(posedge clk) begin
      if (!rst_n || clr_i) begin
        pattern_err_o <= 1'b0;
        err_cnt_o     <= '0;
        err_x_o       <= '0;
        err_y_o       <= '0;
      end else if (mismatch) begin
        pattern_err_o <= 1'b1;
        if (err_cnt_o != ERR_MAX) err_cnt_o <= err_cnt_o + ERR_CNT_WIDTH'(1);
        if (err_cnt_o == '0) begin
          err_x_o <= pix_x;
          err_y_o <= pix_y;
        end
      end
    end
  end else begin : g_no_pat
    assign pattern_err_o = 1'b0;
    assign err_cnt_o     = '0;
    assign err_x_o       = '0;
    assign err_y_o       = '0;
  end

endmodule
